// File: rtl/color_pkg.sv
// Shared definitions for the TCS3200 RGB sampler: filter codes, FSM/channel
// encodings, output width and small arithmetic helpers.
package color_pkg;

  localparam int NORM_W = 16;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_GREEN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_COUNT  = 2'd2,
    ST_STORE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } chan_t;

  // Clamp a widened count into the 16-bit result range.
  function automatic logic [NORM_W-1:0] sat16(input logic [31:0] x);
    logic [NORM_W-1:0] res;
    if (x > 32'h0000_FFFF) begin
      res = 16'hFFFF;
    end else begin
      res = x[15:0];
    end
    return res;
  endfunction

  function automatic logic [1:0] filt_code(input chan_t ch);
    logic [1:0] code;
    case (ch)
      CH_R:    code = FILT_RED;
      CH_G:    code = FILT_GREEN;
      CH_B:    code = FILT_BLUE;
      default: code = FILT_RED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/tcs3200_rgb_sampler_if.sv
// Sensor pins and published RGB result bus of the TCS3200 sampler.
interface tcs3200_rgb_sampler_if;
  import color_pkg::*;

  logic              enable;
  logic              sensor_out;
  logic              s0;
  logic              s1;
  logic              s2;
  logic              s3;
  logic              oe_n;
  logic [NORM_W-1:0] red_norm;
  logic [NORM_W-1:0] green_norm;
  logic [NORM_W-1:0] blue_norm;
  logic              valid;
  logic              busy;

  modport master (
    input  enable, sensor_out,
    output s0, s1, s2, s3, oe_n,
    output red_norm, green_norm, blue_norm, valid, busy
  );

  modport slave (
    output enable, sensor_out,
    input  s0, s1, s2, s3, oe_n,
    input  red_norm, green_norm, blue_norm, valid, busy
  );

endinterface

// File: rtl/tcs_edge_sync.sv
// Two-flop synchroniser for the asynchronous sensor pin followed by a
// registered rising-edge detector (one-cycle pulse per pin rise).
module tcs_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic prev_r;
  logic rise_r;

  // Synchronise the pin and flag a 0->1 transition of the synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      rise_r  <= sync2_r & ~prev_r;
    end
  end

  assign rise_pulse = rise_r;

endmodule

// File: rtl/tcs3200_rgb_sampler.sv
// Steps the TCS3200 filter through red, green and blue, counts sensor edges in a
// fixed gate window per channel and publishes all three 16-bit values together.
module tcs3200_rgb_sampler
  import color_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 5000,
  parameter int         GATE_CYCLES   = 500000,
  parameter int         CNT_W         = 20,
  parameter int         NORM_SHIFT    = 0,
  parameter logic [1:0] FREQ_SCALE    = 2'b10
) (
  input logic                   clk,
  input logic                   rst_n,
  tcs3200_rgb_sampler_if.master bus
);

  state_t            state_r;
  state_t            state_nx_s;
  chan_t             ch_r;
  chan_t             ch_nx_s;
  logic [31:0]       timer_r;
  logic [CNT_W-1:0]  edge_cnt_r;
  logic [CNT_W-1:0]  shifted_s;
  logic [NORM_W-1:0] store_val_s;
  logic [NORM_W-1:0] shadow_red_r;
  logic [NORM_W-1:0] shadow_green_r;
  logic              rise_s;
  logic              settle_done_s;
  logic              gate_done_s;

  logic [1:0]        filt_nx_s;
  logic              oe_n_nx_s;
  logic              busy_nx_s;
  logic              publish_s;

  logic              s2_r;
  logic              s3_r;
  logic              oe_n_r;
  logic              busy_r;
  logic              valid_r;
  logic [NORM_W-1:0] red_r;
  logic [NORM_W-1:0] green_r;
  logic [NORM_W-1:0] blue_r;

  tcs_edge_sync u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (bus.sensor_out),
    .rise_pulse (rise_s)
  );

  assign settle_done_s = (timer_r == 32'(SETTLE_CYCLES - 1));
  assign gate_done_s   = (timer_r == 32'(GATE_CYCLES - 1));
  assign shifted_s     = edge_cnt_r >> NORM_SHIFT;
  assign store_val_s   = sat16(32'(shifted_s));

  // FSM state and channel register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ch_r    <= CH_R;
    end else begin
      state_r <= state_nx_s;
      ch_r    <= ch_nx_s;
    end
  end

  // Next-state and next-channel decode; dropping enable aborts only while measuring.
  always_comb begin
    state_nx_s = state_r;
    ch_nx_s    = ch_r;
    case (state_r)
      ST_IDLE: begin
        ch_nx_s = CH_R;
        if (bus.enable) begin
          state_nx_s = ST_SETTLE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!bus.enable) begin
          state_nx_s = ST_IDLE;
          ch_nx_s    = CH_R;
        end else if (settle_done_s) begin
          state_nx_s = ST_COUNT;
        end else begin
          state_nx_s = ST_SETTLE;
        end
      end
      ST_COUNT: begin
        if (!bus.enable) begin
          state_nx_s = ST_IDLE;
          ch_nx_s    = CH_R;
        end else if (gate_done_s) begin
          state_nx_s = ST_STORE;
        end else begin
          state_nx_s = ST_COUNT;
        end
      end
      ST_STORE: begin
        case (ch_r)
          CH_R: begin
            state_nx_s = ST_SETTLE;
            ch_nx_s    = CH_G;
          end
          CH_G: begin
            state_nx_s = ST_SETTLE;
            ch_nx_s    = CH_B;
          end
          default: begin
            ch_nx_s = CH_R;
            if (bus.enable) begin
              state_nx_s = ST_SETTLE;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end
        endcase
      end
      default: begin
        state_nx_s = ST_IDLE;
        ch_nx_s    = CH_R;
      end
    endcase
  end

  // Next values of the registered sensor-control and status outputs.
  always_comb begin
    filt_nx_s = filt_code(ch_nx_s);
    oe_n_nx_s = (state_nx_s == ST_IDLE);
    busy_nx_s = (state_nx_s != ST_IDLE);
    if ((state_r == ST_STORE) && (ch_r == CH_B)) begin
      publish_s = 1'b1;
    end else begin
      publish_s = 1'b0;
    end
  end

  // Phase timer restarts on every state change and idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= 32'd0;
    end else if ((state_nx_s != state_r) || (state_r == ST_IDLE)) begin
      timer_r <= 32'd0;
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

  // Edge counter: held clear during settling, saturating while gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_SETTLE) begin
      edge_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_COUNT) && rise_s && (edge_cnt_r != {CNT_W{1'b1}})) begin
      edge_cnt_r <= edge_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      edge_cnt_r <= edge_cnt_r;
    end
  end

  // Per-channel shadows; blue needs none because it publishes straight from the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_red_r   <= 16'h0000;
      shadow_green_r <= 16'h0000;
    end else if ((state_r == ST_STORE) && (ch_r == CH_R)) begin
      shadow_red_r <= store_val_s;
    end else if ((state_r == ST_STORE) && (ch_r == CH_G)) begin
      shadow_green_r <= store_val_s;
    end else begin
      shadow_red_r   <= shadow_red_r;
      shadow_green_r <= shadow_green_r;
    end
  end

  // Output registers: all three results load on one edge, together with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_r    <= 1'b0;
      s3_r    <= 1'b0;
      oe_n_r  <= 1'b1;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      red_r   <= 16'h0000;
      green_r <= 16'h0000;
      blue_r  <= 16'h0000;
    end else begin
      s2_r    <= filt_nx_s[1];
      s3_r    <= filt_nx_s[0];
      oe_n_r  <= oe_n_nx_s;
      busy_r  <= busy_nx_s;
      valid_r <= publish_s;
      if (publish_s) begin
        red_r   <= shadow_red_r;
        green_r <= shadow_green_r;
        blue_r  <= store_val_s;
      end else begin
        red_r   <= red_r;
        green_r <= green_r;
        blue_r  <= blue_r;
      end
    end
  end

  assign bus.s0         = FREQ_SCALE[1];
  assign bus.s1         = FREQ_SCALE[0];
  assign bus.s2         = s2_r;
  assign bus.s3         = s3_r;
  assign bus.oe_n       = oe_n_r;
  assign bus.busy       = busy_r;
  assign bus.valid      = valid_r;
  assign bus.red_norm   = red_r;
  assign bus.green_norm = green_r;
  assign bus.blue_norm  = blue_r;

endmodule
